// File: rtl/multicycle_control_fsm_pkg.sv
// Shared types and encodings for the multicycle MIPS main controller.
// CTRL_ADDI_EN adds the ADDIEXEC/ADDIWB states for addi support.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTE  = 4'd6,
        ALUWB    = 4'd7,
        BRANCH   = 4'd8,
`ifdef CTRL_ADDI_EN
        JUMP     = 4'd9,
        ADDIEXEC = 4'd10,
        ADDIWB   = 4'd11
`else
        JUMP     = 4'd9
`endif
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_t;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

endpackage

// File: rtl/multicycle_control_fsm_if.sv
// Controller <-> datapath bundle: instruction fields and ALU zero in, control strobes out.
// The slave modport is the controller side.
interface multicycle_control_fsm_if #(parameter int STATE_W = 4);
    logic [5:0]         op;
    logic [5:0]         funct;
    logic               zero;
    logic               pcen;
    logic [1:0]         pcsrc;
    logic               iord;
    logic               memwrite;
    logic               irwrite;
    logic               regdst;
    logic               memtoreg;
    logic               regwrite;
    logic               alusrca;
    logic [1:0]         alusrcb;
    logic [2:0]         alucontrol;
    logic               illegal_op;
    logic [STATE_W-1:0] state_o;

    modport master (
        output op, funct, zero,
        input  pcen, pcsrc, iord, memwrite, irwrite, regdst, memtoreg, regwrite,
               alusrca, alusrcb, alucontrol, illegal_op, state_o
    );

    modport slave (
        input  op, funct, zero,
        output pcen, pcsrc, iord, memwrite, irwrite, regdst, memtoreg, regwrite,
               alusrca, alusrcb, alucontrol, illegal_op, state_o
    );
endinterface

// File: rtl/multicycle_control_fsm_alu_decoder.sv
// ALU decoder: maps aluop and funct to the ALU control code; flags unknown funct
// values when the funct field is actually consulted.
module alu_decoder
    import mips_ctrl_pkg::*;
(
    input  aluop_t     aluop,
    input  logic [5:0] funct,
    output logic [2:0] alucontrol,
    output logic       bad_funct
);

    always_comb begin
        alucontrol = ALU_ADD;
        bad_funct  = 1'b0;
        case (aluop)
            ALUOP_SUB: alucontrol = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    FUNCT_ADD: alucontrol = ALU_ADD;
                    FUNCT_SUB: alucontrol = ALU_SUB;
                    FUNCT_AND: alucontrol = ALU_AND;
                    FUNCT_OR:  alucontrol = ALU_OR;
                    FUNCT_SLT: alucontrol = ALU_SLT;
                    default:   bad_funct  = 1'b1;
                endcase
            end
            default: alucontrol = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multicycle MIPS main controller: Moore FSM sequencing fetch/decode/execute/mem/writeback.
// Define CTRL_ADDI_EN to support addi; otherwise opcode 001000 is reported as illegal.
module multicycle_control_fsm
    import mips_ctrl_pkg::*;
#(
    parameter int STATE_W = 4
) (
    input logic                     clk,
    input logic                     rst,
    multicycle_control_fsm_if.slave bus
);

    state_t     state;
    state_t     next_state;
    aluop_t     aluop;
    logic       pcwrite;
    logic       branch;
    logic [1:0] pcsrc;
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic       bad_op;
    logic       check_funct;
    logic       valid_state;
    logic       active;
    logic [2:0] alucontrol_raw;
    logic       bad_funct;

    always_ff @(posedge clk) begin
        if (rst) state <= FETCH;
        else     state <= next_state;
    end

    always_comb begin
        next_state  = FETCH;
        aluop       = ALUOP_ADD;
        pcwrite     = 1'b0;
        branch      = 1'b0;
        pcsrc       = 2'b00;
        iord        = 1'b0;
        memwrite    = 1'b0;
        irwrite     = 1'b0;
        regdst      = 1'b0;
        memtoreg    = 1'b0;
        regwrite    = 1'b0;
        alusrca     = 1'b0;
        alusrcb     = 2'b00;
        bad_op      = 1'b0;
        check_funct = 1'b0;
        valid_state = 1'b1;
        case (state)
            FETCH: begin
                irwrite    = 1'b1;
                pcwrite    = 1'b1;
                alusrcb    = 2'b01;
                next_state = DECODE;
            end
            DECODE: begin
                alusrcb = 2'b11;
                case (bus.op)
                    OP_LW, OP_SW: next_state = MEMADR;
                    OP_RTYPE:     next_state = EXECUTE;
                    OP_BEQ:       next_state = BRANCH;
                    OP_J:         next_state = JUMP;
`ifdef CTRL_ADDI_EN
                    OP_ADDI:      next_state = ADDIEXEC;
`endif
                    default:      bad_op     = 1'b1;
                endcase
            end
            MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                if (bus.op == OP_LW)      next_state = MEMREAD;
                else if (bus.op == OP_SW) next_state = MEMWRITE;
            end
            MEMREAD: begin
                iord       = 1'b1;
                next_state = MEMWB;
            end
            MEMWB: begin
                regwrite = 1'b1;
                memtoreg = 1'b1;
            end
            MEMWRITE: begin
                iord     = 1'b1;
                memwrite = 1'b1;
            end
            EXECUTE: begin
                alusrca     = 1'b1;
                aluop       = ALUOP_FUNCT;
                check_funct = 1'b1;
                next_state  = ALUWB;
            end
            ALUWB: begin
                regwrite = 1'b1;
                regdst   = 1'b1;
            end
            BRANCH: begin
                alusrca = 1'b1;
                aluop   = ALUOP_SUB;
                pcsrc   = 2'b01;
                branch  = 1'b1;
            end
`ifdef CTRL_ADDI_EN
            ADDIEXEC: begin
                alusrca    = 1'b1;
                alusrcb    = 2'b10;
                next_state = ADDIWB;
            end
            ADDIWB: regwrite = 1'b1;
`endif
            JUMP: begin
                pcwrite = 1'b1;
                pcsrc   = 2'b10;
            end
            default: valid_state = 1'b0;
        endcase
    end

    alu_decoder u_alu_decoder (
        .aluop      (aluop),
        .funct      (bus.funct),
        .alucontrol (alucontrol_raw),
        .bad_funct  (bad_funct)
    );

    // Reset and corrupted state encodings both silence every control strobe.
    assign active          = !rst && valid_state;
    assign bus.pcen        = active & (pcwrite | (branch & bus.zero));
    assign bus.pcsrc       = active ? pcsrc : 2'b00;
    assign bus.iord        = active & iord;
    assign bus.memwrite    = active & memwrite;
    assign bus.irwrite     = active & irwrite;
    assign bus.regdst      = active & regdst;
    assign bus.memtoreg    = active & memtoreg;
    assign bus.regwrite    = active & regwrite;
    assign bus.alusrca     = active & alusrca;
    assign bus.alusrcb     = active ? alusrcb : 2'b00;
    assign bus.alucontrol  = active ? alucontrol_raw : 3'b000;
    assign bus.illegal_op  = active & (bad_op | (check_funct & bad_funct));
    assign bus.state_o     = rst ? '0 : STATE_W'(state);

endmodule
